// File: rtl/bias_seq_pkg.sv
// bias_seq_pkg: shared state encoding and mode constants for the bias sequencer
package bias_seq_pkg;
  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_DRAIN  = 3'd1,
    S_RAMP_L = 3'd2,
    S_RAMP_H = 3'd3,
    S_READY  = 3'd4
  } state_t;
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_L   = 2'b01;
  localparam logic [1:0] MODE_H   = 2'b10;
  localparam logic [1:0] MODE_LH  = 2'b11;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter, done while the count sits at zero
module settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (start) cnt <= load;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/bias_seq_ctrl.sv
// bias_seq_ctrl: break-before-make power-up/mode sequencer for the EN_RESL/EN_RESH bias branches
module bias_seq_ctrl
  import bias_seq_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SETTLE_L = 1000,
  parameter int SETTLE_H = 1000,
  parameter int DRAIN    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] mode_req,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       en_resl,
  output logic       en_resh,
  output logic       bias_ready,
  output logic       busy,
  output logic [2:0] state_o
);
  // Each timed state lasts exactly N cycles, so the timer is loaded with N-1 on entry
  localparam logic [CNT_W-1:0] LD_L = CNT_W'((SETTLE_L == 0 ? 1 : SETTLE_L) - 1);
  localparam logic [CNT_W-1:0] LD_H = CNT_W'((SETTLE_H == 0 ? 1 : SETTLE_H) - 1);
  localparam logic [CNT_W-1:0] LD_D = CNT_W'((DRAIN == 0 ? 1 : DRAIN) - 1);
  state_t     state, nxt;
  logic [1:0] cur, tgt, sel, drop, add, cur_nxt, en_nxt;
  logic       done, acc;
  assign mode_ready = ena && (state == S_OFF || state == S_READY);
  assign busy       = state == S_DRAIN || state == S_RAMP_L || state == S_RAMP_H;
  assign state_o    = state;
  assign acc        = mode_valid && mode_ready;
  // While idle the live request is the target; once sequencing, the latched one
  always_comb begin
    sel     = mode_ready ? mode_req : tgt;
    drop    = cur & ~sel;
    add     = sel & ~cur;
    nxt     = state;
    cur_nxt = cur;
    case (state)
      S_OFF, S_READY:
        if (acc) nxt = drop != MODE_OFF ? S_DRAIN : add[0] ? S_RAMP_L : add[1] ? S_RAMP_H :
                       sel != MODE_OFF ? S_READY : S_OFF;
      S_DRAIN:
        if (done) begin
          nxt     = add[0] ? S_RAMP_L : add[1] ? S_RAMP_H : tgt != MODE_OFF ? S_READY : S_OFF;
          cur_nxt = cur & tgt;
        end
      S_RAMP_L:
        if (done) begin
          nxt     = add[1] ? S_RAMP_H : S_READY;
          cur_nxt = cur | MODE_L;
        end
      S_RAMP_H:
        if (done) begin
          nxt     = S_READY;
          cur_nxt = cur | MODE_H;
        end
      default: nxt = S_OFF;
    endcase
    en_nxt = nxt == S_DRAIN ? cur & sel :
             cur_nxt | (nxt == S_RAMP_L ? MODE_L : MODE_OFF) | (nxt == S_RAMP_H ? MODE_H : MODE_OFF);
  end
  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!ena),
    .start(nxt != state),
    .load (nxt == S_DRAIN ? LD_D : nxt == S_RAMP_L ? LD_L : LD_H),
    .done (done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_OFF;
      cur        <= MODE_OFF;
      tgt        <= MODE_OFF;
      en_resl    <= 1'b0;
      en_resh    <= 1'b0;
      bias_ready <= 1'b0;
    end else if (!ena) begin
      state      <= S_OFF;
      cur        <= MODE_OFF;
      tgt        <= MODE_OFF;
      en_resl    <= 1'b0;
      en_resh    <= 1'b0;
      bias_ready <= 1'b0;
    end else begin
      state              <= nxt;
      cur                <= cur_nxt;
      tgt                <= acc ? mode_req : tgt;
      {en_resh, en_resl} <= en_nxt;
      bias_ready         <= nxt == S_READY && cur_nxt != MODE_OFF;
    end
endmodule

// File: tb/tb_bias_seq_ctrl.sv
// tb_bias_seq_ctrl: directed sequencing scenarios with SETTLE_L=4, SETTLE_H=6, DRAIN=3
module tb_bias_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena, mode_valid;
  logic [1:0] mode_req;
  logic       mode_ready, en_resl, en_resh, bias_ready, busy;
  logic [2:0] state_o;
  int n_cmp = 0;
  int n_err = 0;

  bias_seq_ctrl #(.CNT_W(16), .SETTLE_L(4), .SETTLE_H(6), .DRAIN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode_req  (mode_req),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .en_resl   (en_resl),
    .en_resh   (en_resh),
    .bias_ready(bias_ready),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs the status outputs: {bias_ready, mode_ready, busy, en_resh, en_resl, state}
  function automatic logic [7:0] st();
    return {bias_ready, mode_ready, busy, en_resh, en_resl, state_o};
  endfunction

  function automatic logic [7:0] ex(input logic br, mr, bz, eh, el, input logic [2:0] s);
    return {br, mr, bz, eh, el, s};
  endfunction

  task automatic request(input logic [1:0] m);
    mode_req   = m;
    mode_valid = 1'b1;
    tick();
    mode_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; mode_valid = 1'b0; mode_req = 2'b00;
    #12;
    chk("reset_no_ena", st(), ex(0, 0, 0, 0, 0, 3'd0));
    rst_n = 1'b1;
    tick();
    chk("off_ena0", st(), ex(0, 0, 0, 0, 0, 3'd0));
    ena = 1'b1;
    tick();
    chk("t1_idle", st(), ex(0, 1, 0, 0, 0, 3'd0));

    // Power-up to L+H: L ramps first, then H
    request(2'b11);
    chk("t2_c1", st(), ex(0, 0, 1, 0, 1, 3'd2));
    tick(3);
    chk("t2_c4", st(), ex(0, 0, 1, 0, 1, 3'd2));
    tick();
    chk("t2_c5", st(), ex(0, 0, 1, 1, 1, 3'd3));
    tick(5);
    chk("t2_c10", st(), ex(0, 0, 1, 1, 1, 3'd3));
    tick();
    chk("t2_c11", st(), ex(1, 1, 0, 1, 1, 3'd4));

    // Shed H only: drain, no ramp
    request(2'b01);
    chk("t3_c1", st(), ex(0, 0, 1, 0, 1, 3'd1));
    tick(2);
    chk("t3_c3", st(), ex(0, 0, 1, 0, 1, 3'd1));
    tick();
    chk("t3_c4", st(), ex(1, 1, 0, 0, 1, 3'd4));

    // L -> H: break before make
    request(2'b10);
    chk("t4_c1", st(), ex(0, 0, 1, 0, 0, 3'd1));
    tick(3);
    chk("t4_c4", st(), ex(0, 0, 1, 1, 0, 3'd3));
    for (int i = 5; i <= 9; i++) begin
      tick();
      chk("t4_overlap", {7'd0, en_resl & en_resh}, 8'd0);
    end
    chk("t4_c9", st(), ex(0, 0, 1, 1, 0, 3'd3));
    tick();
    chk("t4_c10", st(), ex(1, 1, 0, 1, 0, 3'd4));

    // Request held through RAMP_L, accepted on the first READY cycle
    request(2'b11);
    mode_req = 2'b01; mode_valid = 1'b1;
    chk("t5_c1", st(), ex(0, 0, 1, 1, 1, 3'd2));
    tick(3);
    chk("t5_c4", st(), ex(0, 0, 1, 1, 1, 3'd2));
    tick();
    chk("t5_c5", st(), ex(1, 1, 0, 1, 1, 3'd4));
    tick();
    mode_valid = 1'b0;
    chk("t5_c6", st(), ex(0, 0, 1, 0, 1, 3'd1));
    tick(3);
    chk("t5_c9", st(), ex(1, 1, 0, 0, 1, 3'd4));

    // ena drop mid RAMP_H
    request(2'b11);
    chk("t6_c1", st(), ex(0, 0, 1, 1, 1, 3'd3));
    tick();
    ena = 1'b0;
    tick();
    chk("t6_ena0", st(), ex(0, 0, 0, 0, 0, 3'd0));
    ena = 1'b1;
    #1;
    chk("t6_ena1", st(), ex(0, 1, 0, 0, 0, 3'd0));
    tick(3);
    chk("t6_no_restore", st(), ex(0, 1, 0, 0, 0, 3'd0));

    // Same-mode request while OFF stays OFF
    request(2'b00);
    chk("same_off", st(), ex(0, 1, 0, 0, 0, 3'd0));

    // Asynchronous reset mid-ramp
    request(2'b01);
    chk("ar_ramp", st(), ex(0, 0, 1, 0, 1, 3'd2));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async", st(), ex(0, 1, 0, 0, 0, 3'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
